// File: rtl/branch_seq_if.sv
// Register-file read port used by the branch sequencer to fetch Ra.
// The master side issues the request and index; the slave side (register
// file) answers with an acknowledge and the register contents in the same cycle.
interface branch_seq_if #(
    parameter int DATA_W = 32
);
    logic              ra_req;
    logic [3:0]        ra_sel;
    logic              ra_ack;
    logic [DATA_W-1:0] ra_data;

    modport master (
        output ra_req,
        output ra_sel,
        input  ra_ack,
        input  ra_data
    );

    modport slave (
        input  ra_req,
        input  ra_sel,
        output ra_ack,
        output ra_data
    );
endinterface

// File: rtl/branch_seq.sv
// Branch-resolution sequencer: on start it fetches Ra from the register file,
// evaluates the 2-bit branch condition, computes pc_in + sext(offset) and
// reports the outcome with a one-cycle done / pc_load pulse.
// Every output comes straight from a flop; nothing is combinational from inputs.
module branch_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] IR,
    input  logic [DATA_W-1:0] pc_in,
    branch_seq_if.master      rf,
    output logic              busy,
    output logic              done,
    output logic              taken,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] EVAL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        cond_q;
    logic [18:0]       offset_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] ra_val;

    logic              cond_met;
    logic [DATA_W-1:0] target;

    // Only the Ra select, condition and offset fields of IR are meaningful here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{IR[DATA_W-1:27], IR[22:21]};

    // Condition evaluation on the captured Ra value and the branch target sum.
    always_comb begin
        cond_met = 1'b0;
        case (cond_q)
            2'b00:   cond_met = (ra_val == '0);
            2'b01:   cond_met = (ra_val != '0);
            2'b10:   cond_met = ~ra_val[DATA_W-1];
            default: cond_met = ra_val[DATA_W-1];
        endcase
        target = pc_q + {{(DATA_W-19){offset_q[18]}}, offset_q};
    end

    // Sequencer state machine; all outputs are registered alongside the state.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state     <= IDLE;
            cond_q    <= '0;
            offset_q  <= '0;
            pc_q      <= '0;
            ra_val    <= '0;
            rf.ra_req <= 1'b0;
            rf.ra_sel <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            taken     <= 1'b0;
            pc_load   <= 1'b0;
            pc_out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    pc_load <= 1'b0;
                    if (start) begin
                        cond_q    <= IR[20:19];
                        offset_q  <= IR[18:0];
                        pc_q      <= pc_in;
                        rf.ra_sel <= IR[26:23];
                        rf.ra_req <= 1'b1;
                        busy      <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (rf.ra_ack) begin
                        ra_val    <= rf.ra_data;
                        rf.ra_req <= 1'b0;
                        state     <= EVAL;
                    end
                end
                EVAL: begin
                    taken   <= cond_met;
                    pc_load <= cond_met;
                    pc_out  <= cond_met ? target : pc_q;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    pc_load <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    rf.ra_req <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    pc_load   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
